// File: rtl/flipper_bus_pkg.sv
// Shared FSM state type and constants for the CPU-to-register-unit bus router.
package flipper_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } rtr_state_t;

    localparam int DEF_SEL_W = 4;
    localparam int ERR_RDATA = 0;

endpackage

// File: rtl/cpu_bus_router.sv
// Single-outstanding CPU bus router to NUM_UNITS register units, selected by the top address bits.
// Optional WAIT-state watchdog enabled by defining CPU_BUS_ROUTER_TIMEOUT_EN.
//
// state | meaning
// IDLE  | ready for a CPU request; latches it on up_req_valid
// ISSUE | one-cycle read/write strobe to the selected unit
// WAIT  | holding address/data until the selected unit acks (or times out)
// RESP  | response held on the upstream side until up_rsp_ready
module cpu_bus_router
    import flipper_bus_pkg::*;
#(
    parameter int NUM_UNITS = 4,
    parameter int ADDR_W    = 16,
    parameter int SEL_W     = DEF_SEL_W,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        up_req_valid,
    output logic                        up_req_ready,
    input  logic                        up_req_write,
    input  logic [ADDR_W-1:0]           up_req_addr,
    input  logic [DATA_W-1:0]           up_req_wdata,
    output logic                        up_rsp_valid,
    input  logic                        up_rsp_ready,
    output logic [DATA_W-1:0]           up_rsp_rdata,
    output logic                        up_rsp_err,
    output logic [NUM_UNITS-1:0]        unit_rd,
    output logic [NUM_UNITS-1:0]        unit_wr,
    output logic [ADDR_W-SEL_W-1:0]     unit_addr,
    output logic [DATA_W-1:0]           unit_wdata,
    input  logic [NUM_UNITS-1:0]        unit_ack,
    input  logic [NUM_UNITS*DATA_W-1:0] unit_rdata
);

    rtr_state_t                r_state;
    logic                      r_write;
    logic [SEL_W-1:0]          r_sel;
    logic [ADDR_W-SEL_W-1:0]   r_unit_addr;
    logic [DATA_W-1:0]         r_unit_wdata;
    logic [DATA_W-1:0]         r_rsp_rdata;
    logic                      r_rsp_err;

    rtr_state_t                w_state_nxt;
    logic [SEL_W-1:0]          w_req_sel;
    logic                      w_req_sel_ok;
    logic [NUM_UNITS-1:0]      w_sel_oh;
    logic                      w_ack_hit;
    logic                      w_tmo_hit;
    logic [DATA_W-1:0]         w_rdata_sel;
    logic                      w_rsp_load;
    logic                      w_rsp_err;
    logic [DATA_W-1:0]         w_rsp_rdata;

    assign w_req_sel    = up_req_addr[ADDR_W-1 -: SEL_W];
    assign w_req_sel_ok = (32'(w_req_sel) < 32'(NUM_UNITS));
    // Everything downstream keys off the latched selector, never the live address.
    assign w_sel_oh     = NUM_UNITS'(1) << r_sel;
    assign w_ack_hit    = |(unit_ack & w_sel_oh);

    always_comb begin
        w_rdata_sel = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (w_sel_oh[i]) begin
                w_rdata_sel = w_rdata_sel | unit_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef CPU_BUS_ROUTER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] r_tmo_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tmo_cnt <= '0;
        end else if (r_state == ST_ISSUE) begin
            r_tmo_cnt <= '0;
        end else if (r_state == ST_WAIT) begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end
    end

    assign w_tmo_hit = (r_state == ST_WAIT) && (r_tmo_cnt == TMO_W'(TIMEOUT - 1));
`else
    assign w_tmo_hit = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_rsp_load  = 1'b0;
        w_rsp_err   = 1'b0;
        w_rsp_rdata = DATA_W'(ERR_RDATA);
        case (r_state)
            ST_IDLE: begin
                if (up_req_valid) begin
                    if (w_req_sel_ok) begin
                        w_state_nxt = ST_ISSUE;
                    end else begin
                        w_state_nxt = ST_RESP;
                        w_rsp_load  = 1'b1;
                        w_rsp_err   = 1'b1;
                    end
                end
            end
            ST_ISSUE, ST_WAIT: begin
                if (w_ack_hit) begin
                    w_state_nxt = ST_RESP;
                    w_rsp_load  = 1'b1;
                    if (!r_write) begin
                        w_rsp_rdata = w_rdata_sel;
                    end
                end else if (w_tmo_hit) begin
                    w_state_nxt = ST_RESP;
                    w_rsp_load  = 1'b1;
                    w_rsp_err   = 1'b1;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (up_rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_write      <= 1'b0;
            r_sel        <= '0;
            r_unit_addr  <= '0;
            r_unit_wdata <= '0;
            r_rsp_rdata  <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && up_req_valid) begin
                r_write      <= up_req_write;
                r_sel        <= w_req_sel;
                r_unit_addr  <= up_req_addr[ADDR_W-SEL_W-1:0];
                r_unit_wdata <= up_req_wdata;
            end
            if (w_rsp_load) begin
                r_rsp_rdata <= w_rsp_rdata;
                r_rsp_err   <= w_rsp_err;
            end
        end
    end

    // Gated by resetn so the CPU never sees ready while the block is held in reset.
    assign up_req_ready = resetn && (r_state == ST_IDLE);
    assign up_rsp_valid = (r_state == ST_RESP);
    assign up_rsp_rdata = r_rsp_rdata;
    assign up_rsp_err   = r_rsp_err;
    assign unit_rd      = (r_state == ST_ISSUE && !r_write) ? w_sel_oh : '0;
    assign unit_wr      = (r_state == ST_ISSUE &&  r_write) ? w_sel_oh : '0;
    assign unit_addr    = r_unit_addr;
    assign unit_wdata   = r_unit_wdata;

endmodule

// File: tb/tb_cpu_bus_router.sv
// Self-checking bench for cpu_bus_router: vector table plus backpressure, timeout and reset sequences.
// Timeout expectations follow CPU_BUS_ROUTER_TIMEOUT_EN as seen by the bench compile.
module tb_cpu_bus_router;

    localparam int NU = 4;
    localparam int AW = 16;
    localparam int DW = 32;

    logic           clk;
    logic           resetn;
    logic           up_req_valid;
    logic           up_req_ready;
    logic           up_req_write;
    logic [AW-1:0]  up_req_addr;
    logic [DW-1:0]  up_req_wdata;
    logic           up_rsp_valid;
    logic           up_rsp_ready;
    logic [DW-1:0]  up_rsp_rdata;
    logic           up_rsp_err;
    logic [NU-1:0]  unit_rd;
    logic [NU-1:0]  unit_wr;
    logic [11:0]    unit_addr;
    logic [DW-1:0]  unit_wdata;
    logic [NU-1:0]  tb_ack;
    logic [NU*DW-1:0] tb_rdata;

    cpu_bus_router #(
        .NUM_UNITS (NU),
        .ADDR_W    (AW),
        .SEL_W     (4),
        .DATA_W    (DW),
        .TIMEOUT   (8)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .up_req_valid (up_req_valid),
        .up_req_ready (up_req_ready),
        .up_req_write (up_req_write),
        .up_req_addr  (up_req_addr),
        .up_req_wdata (up_req_wdata),
        .up_rsp_valid (up_rsp_valid),
        .up_rsp_ready (up_rsp_ready),
        .up_rsp_rdata (up_rsp_rdata),
        .up_rsp_err   (up_rsp_err),
        .unit_rd      (unit_rd),
        .unit_wr      (unit_wr),
        .unit_addr    (unit_addr),
        .unit_wdata   (unit_wdata),
        .unit_ack     (tb_ack),
        .unit_rdata   (tb_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        write;
        logic [15:0] addr;
        logic [31:0] wdata;
        int          ack_dly;
        logic [31:0] ack_rdata;
        int          stray_c;
        int          stray_u;
        logic [3:0]  exp_rd;
        logic [3:0]  exp_wr;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[8];
    int   n_total = 0;
    int   n_bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic rdata_idle();
        for (int i = 0; i < NU; i++) begin
            tb_rdata[i*DW +: DW] = 32'hD0D0_0000 | 32'(i);
        end
    endtask

    task automatic sb_check(input string name, input int lat);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_total++;
            n_bad++;
            $display("FAIL %s_sb: response with empty scoreboard", name);
            return;
        end
        e = sb_q.pop_front();
        chk({name, "_lat"}, 32'(lat), 32'(e.lat));
        chk({name, "_rdata"}, up_rsp_rdata, e.rdata);
        chk({name, "_err"}, 32'(up_rsp_err), 32'(e.err));
        chk({name, "_req_ready_in_resp"}, 32'(up_req_ready), 32'd0);
    endtask

    task automatic wait_rsp(input int c_start, input int max_cyc, output int lat);
        lat = -1;
        for (int c = c_start; c <= max_cyc; c++) begin
            @(negedge clk);
            up_req_valid = 1'b0;
            if (up_rsp_valid) begin
                lat = c;
                break;
            end
            tb_ack = '0;
            rdata_idle();
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int         sel;
        int         lat;
        int         strobe_cycles;
        logic [3:0] rd_seen;
        logic [3:0] wr_seen;
        string      nm;
        nm  = $sformatf("vec%0d", idx);
        sel = int'(v.addr[15:12]);
        lat = -1;
        strobe_cycles = 0;
        rd_seen = '0;
        wr_seen = '0;
        @(negedge clk);
        chk({nm, "_req_ready"}, 32'(up_req_ready), 32'd1);
        up_req_valid = 1'b1;
        up_req_write = v.write;
        up_req_addr  = v.addr;
        up_req_wdata = v.wdata;
        sb_q.push_back('{v.exp_rdata, v.exp_err, v.exp_lat});
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            up_req_valid = 1'b0;
            if (unit_rd != '0 || unit_wr != '0) strobe_cycles++;
            rd_seen = rd_seen | unit_rd;
            wr_seen = wr_seen | unit_wr;
            if (up_rsp_valid) begin
                lat = c;
                break;
            end
            // the live address now points elsewhere; the router must use the latched selector
            up_req_addr = v.addr ^ 16'h3000;
            tb_ack = '0;
            rdata_idle();
            if (v.stray_c == c) begin
                tb_ack[v.stray_u] = 1'b1;
            end
            if (v.ack_dly >= 0 && c == 1 + v.ack_dly) begin
                chk({nm, "_unit_addr"}, 32'(unit_addr), 32'(v.addr[11:0]));
                if (v.write) chk({nm, "_unit_wdata"}, unit_wdata, v.wdata);
                tb_ack[sel] = 1'b1;
                tb_rdata[sel*DW +: DW] = v.ack_rdata;
            end
        end
        tb_ack = '0;
        rdata_idle();
        chk({nm, "_rd_strobe"}, 32'(rd_seen), 32'(v.exp_rd));
        chk({nm, "_wr_strobe"}, 32'(wr_seen), 32'(v.exp_wr));
        chk({nm, "_strobe_cycles"}, 32'(strobe_cycles), ((v.exp_rd | v.exp_wr) != 4'b0) ? 32'd1 : 32'd0);
        sb_check(nm, lat);
    endtask

    initial begin
        int lat;
        vecs[0] = '{1'b0, 16'h1004, 32'h0,        2,  32'hCAFEF00D, 0, 0, 4'b0010, 4'b0000, 32'hCAFEF00D, 1'b0, 4};
        vecs[1] = '{1'b1, 16'h0010, 32'h12345678, 0,  32'hFFFFFFFF, 0, 0, 4'b0000, 4'b0001, 32'h0,        1'b0, 2};
        vecs[2] = '{1'b0, 16'h7000, 32'h0,        -1, 32'h0,        0, 0, 4'b0000, 4'b0000, 32'h0,        1'b1, 1};
        vecs[3] = '{1'b0, 16'h3ABC, 32'h0,        0,  32'h0BADBEEF, 1, 2, 4'b1000, 4'b0000, 32'h0BADBEEF, 1'b0, 2};
        vecs[4] = '{1'b1, 16'h2FFF, 32'hA5A5A5A5, 3,  32'h11111111, 2, 1, 4'b0000, 4'b0100, 32'h0,        1'b0, 5};
        vecs[5] = '{1'b1, 16'hF123, 32'h00000001, -1, 32'h0,        0, 0, 4'b0000, 4'b0000, 32'h0,        1'b1, 1};
        vecs[6] = '{1'b0, 16'h0000, 32'h0,        1,  32'h00000001, 1, 3, 4'b0001, 4'b0000, 32'h00000001, 1'b0, 3};
        vecs[7] = '{1'b1, 16'h4000, 32'h00000077, -1, 32'h0,        0, 0, 4'b0000, 4'b0000, 32'h0,        1'b1, 1};

        resetn       = 1'b0;
        up_req_valid = 1'b0;
        up_req_write = 1'b0;
        up_req_addr  = '0;
        up_req_wdata = '0;
        up_rsp_ready = 1'b1;
        tb_ack       = '0;
        rdata_idle();

        #3;
        chk("rst_req_ready", 32'(up_req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(up_rsp_valid), 32'd0);
        chk("rst_rsp_rdata", up_rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(up_rsp_err), 32'd0);
        chk("rst_strobes", 32'({unit_rd, unit_wr}), 32'd0);
        chk("rst_unit_addr", 32'(unit_addr), 32'd0);
        chk("rst_unit_wdata", unit_wdata, 32'd0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("post_rst_req_ready", 32'(up_req_ready), 32'd1);

        for (int i = 0; i < 8; i++) begin
            run_vec(i, vecs[i]);
        end

        // backpressure: response must stay put and no new request may be taken
        @(negedge clk);
        up_rsp_ready = 1'b0;
        up_req_valid = 1'b1;
        up_req_write = 1'b0;
        up_req_addr  = 16'h1008;
        sb_q.push_back('{32'h5A5A1234, 1'b0, 4});
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            up_req_valid = 1'b0;
            if (up_rsp_valid) begin
                lat = c;
                break;
            end
            tb_ack = '0;
            rdata_idle();
            if (c == 2) begin
                tb_ack[2] = 1'b1;
                tb_rdata[2*DW +: DW] = 32'hBBBBBBBB;
            end
            if (c == 3) begin
                tb_ack[1] = 1'b1;
                tb_rdata[1*DW +: DW] = 32'h5A5A1234;
            end
        end
        tb_ack = '0;
        rdata_idle();
        sb_check("bp", lat);
        up_req_valid = 1'b1;
        up_req_write = 1'b1;
        up_req_addr  = 16'h0020;
        up_req_wdata = 32'h99999999;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_hold%0d_valid", i), 32'(up_rsp_valid), 32'd1);
            chk($sformatf("bp_hold%0d_rdata", i), up_rsp_rdata, 32'h5A5A1234);
            chk($sformatf("bp_hold%0d_err", i), 32'(up_rsp_err), 32'd0);
            chk($sformatf("bp_hold%0d_req_ready", i), 32'(up_req_ready), 32'd0);
            chk($sformatf("bp_hold%0d_no_strobe", i), 32'({unit_rd, unit_wr}), 32'd0);
        end
        up_req_valid = 1'b0;
        up_rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_done_rsp_valid", 32'(up_rsp_valid), 32'd0);
        chk("bp_done_req_ready", 32'(up_req_ready), 32'd1);

        // unit2 never acks
        @(negedge clk);
        up_req_valid = 1'b1;
        up_req_write = 1'b0;
        up_req_addr  = 16'h2000;
`ifdef CPU_BUS_ROUTER_TIMEOUT_EN
        sb_q.push_back('{32'h0, 1'b1, 10});
        wait_rsp(1, 40, lat);
        sb_check("tmo", lat);
`else
        wait_rsp(1, 1000, lat);
        chk("no_tmo_no_rsp", 32'(lat), 32'hFFFFFFFF);
        tb_ack[2] = 1'b1;
        tb_rdata[2*DW +: DW] = 32'h600DD00D;
        sb_q.push_back('{32'h600DD00D, 1'b0, 1001});
        wait_rsp(1001, 1010, lat);
        sb_check("late_ack", lat);
`endif
        tb_ack = '0;
        rdata_idle();

        // reset while waiting, then a stale ack from the dropped transaction
        @(negedge clk);
        up_req_valid = 1'b1;
        up_req_write = 1'b0;
        up_req_addr  = 16'h1000;
        @(negedge clk);
        up_req_valid = 1'b0;
        chk("rstw_rd_strobe", 32'(unit_rd), 32'b0010);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("rstw_req_ready", 32'(up_req_ready), 32'd0);
        chk("rstw_rsp_valid", 32'(up_rsp_valid), 32'd0);
        chk("rstw_rsp_rdata", up_rsp_rdata, 32'd0);
        chk("rstw_unit_addr", 32'(unit_addr), 32'd0);
        chk("rstw_unit_wdata", unit_wdata, 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("rstw_release_req_ready", 32'(up_req_ready), 32'd1);
        @(negedge clk);
        tb_ack[1] = 1'b1;
        tb_rdata[1*DW +: DW] = 32'hDEADDEAD;
        wait_rsp(1, 6, lat);
        chk("rstw_stale_ack_no_rsp", 32'(lat), 32'hFFFFFFFF);
        chk("rstw_idle_req_ready", 32'(up_req_ready), 32'd1);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cpu_bus_router.md
CPU_BUS_ROUTER -- requirements
Module: cpu_bus_router

Interface
REQ-001 SHALL have parameter NUM_UNITS, default 4: number of downstream register units (1..16).
REQ-002 SHALL have parameter ADDR_W, default 16: upstream address width.
REQ-003 SHALL have parameter SEL_W, default 4: selector field, address bits [ADDR_W-1 : ADDR_W-SEL_W].
REQ-004 SHALL have parameter DATA_W, default 32: data width.
REQ-005 SHALL have parameter TIMEOUT, default 255: WAIT-state cycle limit.
REQ-006 SHALL have port clk, input, 1: the block's only clock.
REQ-007 SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port up_req_valid, input, 1: CPU request present.
REQ-009 SHALL have port up_req_ready, output, 1: router accepts a request.
REQ-010 SHALL have port up_req_write, input, 1: 1 = write, 0 = read.
REQ-011 SHALL have port up_req_addr, input, ADDR_W: full CPU address.
REQ-012 SHALL have port up_req_wdata, input, DATA_W: write data.
REQ-013 SHALL have port up_rsp_valid, output, 1: response present.
REQ-014 SHALL have port up_rsp_ready, input, 1: CPU side takes the response.
REQ-015 SHALL have port up_rsp_rdata, output, DATA_W: read data; 0 for writes and errors.
REQ-016 SHALL have port up_rsp_err, output, 1: unmapped selector or timeout.
REQ-017 SHALL have port unit_rd, output, NUM_UNITS: one-hot read strobe.
REQ-018 SHALL have port unit_wr, output, NUM_UNITS: one-hot write strobe.
REQ-019 SHALL have port unit_addr, output, ADDR_W-SEL_W: shared local address.
REQ-020 SHALL have port unit_wdata, output, DATA_W: shared write data.
REQ-021 SHALL have port unit_ack, input, NUM_UNITS: per-unit completion.
REQ-022 SHALL have port unit_rdata, input, NUM_UNITS*DATA_W: unit i occupies bits [i*DATA_W +: DATA_W].

Function
REQ-023 SHALL use a four-state FSM: IDLE, ISSUE, WAIT, RESP.
REQ-024 up_req_ready SHALL be 1 only in IDLE.
REQ-025 In IDLE, up_req_valid SHALL cause latching of write, addr, wdata and sel.
REQ-026 From IDLE, a request with sel < NUM_UNITS SHALL go to ISSUE; sel >= NUM_UNITS SHALL go to RESP with err=1 and rdata=0, and no strobe SHALL be issued.
REQ-027 ISSUE SHALL last exactly one cycle; unit_rd[sel] or unit_wr[sel] SHALL be high for that cycle only.
REQ-028 unit_addr and unit_wdata SHALL hold the latched values from ISSUE until leaving WAIT.
REQ-029 unit_ack[sel] in ISSUE or WAIT SHALL capture unit_rdata slice sel (reads only), set err=0, and go to RESP.
REQ-030 Minimum latency: accept at cycle 0, strobe at cycle 1, ack at cycle 1, up_rsp_valid at cycle 2.
REQ-031 unit_ack on non-selected units, or outside ISSUE/WAIT, SHALL be ignored.
REQ-032 In RESP, up_rsp_valid SHALL stay 1 with stable rdata/err until up_rsp_ready=1; then go to IDLE.
REQ-033 A new request SHALL NOT be accepted in the cycle the response completes; there is one outstanding transaction maximum.
REQ-034 The rdata mux index SHALL be the latched sel, never the live address.

Reset
REQ-035 resetn low SHALL immediately force state IDLE, with up_req_ready=0 during reset and 1 on the first cycle after release.
REQ-036 resetn low SHALL force up_rsp_valid=0, up_rsp_rdata=0, up_rsp_err=0, unit_rd=0, unit_wr=0, unit_addr=0, unit_wdata=0 and timeout counter=0.
REQ-037 Reset mid-transaction SHALL drop the transaction with no response; a later stale ack SHALL be ignored.

Configuration
REQ-038 With CPU_BUS_ROUTER_TIMEOUT_EN defined, a counter SHALL clear on ISSUE and increment each WAIT cycle; reaching TIMEOUT SHALL go to RESP with err=1 and rdata=0.
REQ-039 Without CPU_BUS_ROUTER_TIMEOUT_EN, WAIT SHALL last indefinitely until ack, and no counter logic SHALL exist.

Structure
REQ-040 Package flipper_bus_pkg SHALL hold the FSM state enum, the default selector width, and the error read-data constant (0).
REQ-041 The block SHALL be a single module with no sub-module; timeout and mux logic stay inline.

Verification
REQ-042 Read: addr 0x1004 with unit1 acking 2 cycles after the strobe and rdata 0xCAFEF00D SHALL give unit_rd=4'b0010 for 1 cycle, unit_addr=0x004, and then rsp rdata=0xCAFEF00D, err=0.
REQ-043 Write: addr 0x0010, wdata 0x12345678, unit0 acking in ISSUE SHALL give unit_wr=4'b0001, and rsp at cycle 2 with rdata=0, err=0.
REQ-044 Unmapped: addr 0x7000 with NUM_UNITS=4 SHALL give no strobe, and rsp err=1, rdata=0, one cycle after accept.
REQ-045 Timeout (macro on, TIMEOUT=8): no ack SHALL give rsp err=1 after 8 WAIT cycles; with the macro off, no rsp SHALL appear within 1000 cycles.
REQ-046 Backpressure plus stray ack: up_rsp_ready held 0 for 5 cycles SHALL keep rsp stable and up_req_ready=0; a unit2 ack during unit1's WAIT SHALL be ignored.
REQ-047 Reset in WAIT, followed by a late unit ack, SHALL give no rsp, state IDLE, and up_req_ready=1 after release.
